case_toggle_sequencer: RTL and testbench
========================================

// Module: case_toggle_sequencer
// PURPOSE
//   Registered, lint-clean producer/consumer stage for the case-driven toggle decoders.
//   - Accepts a WIDTH-bit code over a valid/ready handshake.
//   - Latches the code into a state register and applies the toggle map in a fully
//     specified case statement.
//   - Presents the result downstream over a second valid/ready handshake.
//   - The decoder value is held in a flop, never fed back combinationally.
// PARAMETERS
//   WIDTH   2   width of cmd and data_out (>=1)
//   CNT_W   8   width of the saturating transfer counter xfer_count
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        synchronous reset, active-low
//   cmd_valid   in   1        upstream code valid
//   cmd         in   WIDTH    upstream code
//   cmd_ready   out  1        stage can accept a code
//   data_out    out  WIDTH    mapped result
//   out_valid   out  1        data_out valid
//   out_ready   in   1        downstream accepts data_out
//   xfer_count  out  CNT_W    completed output transfers, saturating
// BEHAVIOUR
//   Clock and reset
//   - Single clock domain.
//   - rst_n is sampled only on the rising edge of clk.
//   - While rst_n=0 at an edge: state=IDLE, code_q=0, data_out=0, out_valid=0,
//     xfer_count=0.
//   - cmd_ready=1 in the first cycle after reset is released.
//   - Reset asserted in any state aborts the operation; no partial transfer is reported.
//   FSM states (2-bit encoding; the state case has a default branch that returns to IDLE)
//   - IDLE
//     - cmd_ready=1.
//     - On cmd_valid&&cmd_ready: code_q<=cmd, go to EVAL. Otherwise stay in IDLE.
//   - EVAL
//     - cmd_ready=0, out_valid=0.
//     - data_out <= map(code_q), go to OUT. Always a single cycle.
//   - OUT
//     - out_valid=1, cmd_ready=0.
//     - data_out and out_valid are held stable until out_ready=1.
//     - On out_valid&&out_ready: xfer_count increments, go to IDLE.
//   Toggle map
//   - map(x) = x with bit0 inverted: 2'b00->2'b01, 2'b01->2'b00, 2'b10->2'b11,
//     2'b11->2'b10.
//   - Implemented as a complete case with an explicit default (default = x ^ 1).
//   - No latch inference.
//   - Width: the result is exactly WIDTH bits, with no truncation or extension.
//   Handshake rules
//   - cmd is sampled only when cmd_valid&&cmd_ready.
//   - cmd_valid high outside IDLE is ignored and not queued; upstream must hold it.
//   - cmd_ready is a registered function of state only, with no combinational path
//     from cmd_valid.
//   - out_valid does not depend combinationally on out_ready.
//   - cmd_ready and out_valid are never both 1.
//   Latency and throughput
//   - Accept at edge T gives out_valid=1 in cycle T+2.
//   - Minimum 3 cycles per code (IDLE, EVAL, OUT).
//   - Back-to-back: out_ready=1 at the first OUT cycle returns to IDLE, and the next
//     accept happens one edge later.
//   Counter
//   - xfer_count saturates at all-ones: no wrap, and it holds at {CNT_W{1'b1}}.
//   - Only a completed output handshake increments it.
// TESTING
//   1. Reset: rst_n=0 for 2 edges with cmd_valid=1 -> out_valid=0, data_out=0,
//      xfer_count=0; cmd_ready=1 after release.
//   2. Map sweep: send 00,01,10,11 with out_ready=1 -> data_out 01,00,11,10, each
//      with out_valid 2 cycles after accept; xfer_count=4.
//   3. Backpressure: cmd=2'b10, out_ready=0 for 5 cycles -> data_out=2'b11 and
//      out_valid=1 held stable; cmd_ready=0 throughout; a new cmd_valid is ignored;
//      xfer_count increments once, on release.
//   4. Reset mid-op: assert rst_n=0 during OUT -> next cycle out_valid=0,
//      state=IDLE, xfer_count=0, no transfer counted.
//   5. Saturation: CNT_W=2, perform 5 transfers -> xfer_count reads 1,2,3,3,3.
//   6. Handshake invariant: random cmd_valid/out_ready for 1000 cycles ->
//      cmd_ready&&out_valid never 1; every accepted code produces exactly one
//      output equal to map(code).

Source files
------------

// File: rtl/case_toggle_sequencer.sv
// Three-state accept / evaluate / present stage that maps a code through the
// bit0 toggle decoder and counts completed output transfers (saturating).
module case_toggle_sequencer #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  input  logic [WIDTH-1:0] i_cmd,
  output logic             o_cmd_ready,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [CNT_W-1:0] o_xfer_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_code;
  logic [WIDTH-1:0] r_data;
  logic             r_cmd_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_xfer_count;
  logic [WIDTH-1:0] w_map;
  logic             w_accept;
  logic             w_done;

  // Both handshake flags come straight from flops, so neither side sees a
  // combinational path from the other side's valid/ready.
  assign w_accept = i_cmd_valid & r_cmd_ready;
  assign w_done   = r_out_valid & i_out_ready;

  // Toggle map: only bit0 changes, upper bits pass through at full width.
  always_comb begin
    w_map = r_code;
    case (r_code[0])
      1'b0:    w_map[0] = 1'b1;
      1'b1:    w_map[0] = 1'b0;
      default: w_map[0] = ~r_code[0];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EVAL;
      EVAL:    w_state_nxt = OUT;
      OUT:     if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_code       <= '0;
      r_data       <= '0;
      r_cmd_ready  <= 1'b1;
      r_out_valid  <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == OUT);
      if (w_accept)
        r_code <= i_cmd;
      if (r_state == EVAL)
        r_data <= w_map;
      if (w_done && (r_xfer_count != {CNT_W{1'b1}}))
        r_xfer_count <= r_xfer_count + 1'b1;
    end
  end

  assign o_cmd_ready  = r_cmd_ready;
  assign o_out_valid  = r_out_valid;
  assign o_data_out   = r_data;
  assign o_xfer_count = r_xfer_count;

endmodule

// File: tb/tb_case_toggle_sequencer.sv
// Scoreboard bench: accepted codes push map(code), output handshakes pop and compare.
module tb_case_toggle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic       out_ready = 1'b0;
  logic       cmd_ready, out_valid;
  logic [1:0] data_out;
  logic [7:0] xfer_count;

  logic       s_cmd_valid = 1'b0;
  logic [1:0] s_cmd = 2'b00;
  logic       s_out_ready = 1'b1;
  logic       s_cmd_ready, s_out_valid;
  logic [1:0] s_data_out;
  logic [1:0] s_xfer_count;

  int checks = 0;
  int errors = 0;
  logic [1:0] sb_q[$];
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  case_toggle_sequencer #(.WIDTH(2), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(cmd_ready), .o_data_out(data_out), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_xfer_count(xfer_count)
  );

  case_toggle_sequencer #(.WIDTH(2), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(s_cmd_valid), .i_cmd(s_cmd),
    .o_cmd_ready(s_cmd_ready), .o_data_out(s_data_out), .o_out_valid(s_out_valid),
    .i_out_ready(s_out_ready), .o_xfer_count(s_xfer_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: sample at the falling edge what the next rising edge will commit.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt = 8'd0;
    end else begin
      chk("inv_rdy_vld", {31'd0, cmd_ready & out_valid}, 32'd0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("sb_empty_pop", {30'd0, data_out}, 32'hFFFF);
        else chk("sb_data", {30'd0, data_out}, {30'd0, sb_q.pop_front()});
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end
      if (cmd_valid && cmd_ready) sb_q.push_back(cmd ^ 2'b01);
    end
  end

  // Drive one code, check the EVAL bubble and the two-cycle latency.
  task automatic send(input logic [1:0] c);
    int n;
    cmd_valid = 1'b1;
    cmd = c;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("eval_out_valid", {31'd0, out_valid}, 32'd0);
    chk("eval_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {30'd0, data_out}, {30'd0, c ^ 2'b01});
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    int n;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset held two edges with cmd_valid asserted
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {30'd0, data_out}, 32'd0);
    chk("rst_cnt", {24'd0, xfer_count}, 32'd0);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    step();
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Map sweep with a free-flowing sink
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(i[1:0]);
    step();
    chk("sweep_cnt", {24'd0, xfer_count}, 32'd4);
    chk("sweep_cnt_model", {24'd0, xfer_count}, {24'd0, exp_cnt});

    // Backpressure: stalled output must hold and ignore new commands
    out_ready = 1'b0;
    send(2'b10);
    cmd_valid = 1'b1;
    cmd = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", {30'd0, data_out}, 32'd3);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_cnt", {24'd0, xfer_count}, 32'd4);
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_cnt", {24'd0, xfer_count}, 32'd5);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset during OUT drops the transfer
    out_ready = 1'b0;
    send(2'b01);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_idle", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_cnt", {24'd0, xfer_count}, 32'd0);
    chk("mid_rst_data", {30'd0, data_out}, 32'd0);
    rst_n = 1'b1;
    step();

    // Random traffic; scoreboard and invariant run in the monitor
    for (int i = 0; i < 1000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd = 2'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rand_sb_drained", sb_q.size(), 32'd0);
    chk("rand_cnt", {24'd0, xfer_count}, {24'd0, exp_cnt});

    // Saturation on a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      s_cmd_valid = 1'b1;
      s_cmd = i[1:0];
      n = 0;
      while (!s_cmd_ready && n < 50) begin step(); n++; end
      if (!s_cmd_ready) chk("sat_accept_timeout", 32'd0, 32'd1);
      step();
      s_cmd_valid = 1'b0;
      n = 0;
      while (!s_out_valid && n < 50) begin step(); n++; end
      if (!s_out_valid) chk("sat_valid_timeout", 32'd0, 32'd1);
      chk("sat_data", {30'd0, s_data_out}, {30'd0, i[1:0] ^ 2'b01});
      step();
      chk("sat_cnt", {30'd0, s_xfer_count}, {30'd0, sat_exp[i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
